// File: rtl/sc_lanectrl_pkg.sv
// sc_lanectrl_pkg: shared state encodings and per-lane shift codes for the lane controller
package sc_lanectrl_pkg;
  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_START    = 4'd1,
    ST_CHECK    = 4'd2,
    ST_INIT     = 4'd3,
    ST_WAIT_REL = 4'd4,
    ST_SHIFT    = 4'd5,
    ST_COUNT    = 4'd6,
    ST_NEST     = 4'd7,
    ST_LEVEL_UP = 4'd8,
    ST_LOSE     = 4'd9
  } state_t;
  localparam logic [1:0] SEL_HOLD  = 2'b11;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  function automatic logic [1:0] sel_dir(input logic right);
    return right ? SEL_RIGHT : SEL_LEFT;
  endfunction
endpackage

// File: rtl/sc_lanectrl_pending.sv
// sc_lanectrl_pending: per-lane tick latch, a tick sets its lane, clear drops it, set wins on collision
module sc_lanectrl_pending #(
  parameter int WIDTH = 4
) (
  input  logic             SC_LANECTRL_PENDING_CLOCK_50,
  input  logic             SC_LANECTRL_PENDING_RESET_InLow,
  input  logic [WIDTH-1:0] SC_LANECTRL_PENDING_T0_InLow,
  input  logic [WIDTH-1:0] SC_LANECTRL_PENDING_clear,
  output logic [WIDTH-1:0] SC_LANECTRL_PENDING_pending_Out
);
  // pending bits: clear then set, so a tick in the clearing cycle is kept
  always_ff @(posedge SC_LANECTRL_PENDING_CLOCK_50 or negedge SC_LANECTRL_PENDING_RESET_InLow)
    if (!SC_LANECTRL_PENDING_RESET_InLow) SC_LANECTRL_PENDING_pending_Out <= '0;
    else SC_LANECTRL_PENDING_pending_Out <= (SC_LANECTRL_PENDING_pending_Out & ~SC_LANECTRL_PENDING_clear) | ~SC_LANECTRL_PENDING_T0_InLow;
endmodule

// File: rtl/sc_lanectrl_fsm.sv
// sc_lanectrl_fsm: background lane shift controller; SC_LANECTRL_FSM_LOSE_HOLD_EN makes LOSE wait for start
module sc_lanectrl_fsm
  import sc_lanectrl_pkg::*;
#(
  parameter int                   NUM_LANES  = 4,
  parameter int                   NUM_LEVELS = 4,
  parameter int                   LEVEL_W    = 2,
  parameter logic [NUM_LANES-1:0] DIR_MASK   = 4'b0101
) (
  input  logic                   SC_LANECTRL_FSM_CLOCK_50,
  input  logic                   SC_LANECTRL_FSM_RESET_InLow,
  input  logic                   SC_LANECTRL_FSM_startButton_InLow,
  input  logic [NUM_LANES-1:0]   SC_LANECTRL_FSM_T0_InLow,
  input  logic                   SC_LANECTRL_FSM_WINF,
  input  logic                   SC_LANECTRL_FSM_WINL,
  input  logic                   SC_LANECTRL_FSM_Lose,
  input  logic                   SC_LANECTRL_FSM_Change_BACKG,
  output logic                   SC_LANECTRL_FSM_clear_OutLow,
  output logic                   SC_LANECTRL_FSM_load_OutLow,
  output logic                   SC_LANECTRL_FSM_upcount_OutLow,
  output logic [2*NUM_LANES-1:0] SC_LANECTRL_FSM_shiftselection_Out,
  output logic [LEVEL_W-1:0]     SC_LANECTRL_FSM_level_Out
);
  state_t               state, nxt;
  logic [NUM_LANES-1:0] pend, pclr;
  logic [LEVEL_W-1:0]   level;
  logic                 start;
  assign start = SC_LANECTRL_FSM_startButton_InLow;
  sc_lanectrl_pending #(.WIDTH(NUM_LANES)) u_pending (
    .SC_LANECTRL_PENDING_CLOCK_50    (SC_LANECTRL_FSM_CLOCK_50),
    .SC_LANECTRL_PENDING_RESET_InLow (SC_LANECTRL_FSM_RESET_InLow),
    .SC_LANECTRL_PENDING_T0_InLow    (SC_LANECTRL_FSM_T0_InLow),
    .SC_LANECTRL_PENDING_clear       (pclr),
    .SC_LANECTRL_PENDING_pending_Out (pend)
  );
  // state register
  always_ff @(posedge SC_LANECTRL_FSM_CLOCK_50 or negedge SC_LANECTRL_FSM_RESET_InLow)
    if (!SC_LANECTRL_FSM_RESET_InLow) state <= ST_RESET;
    else state <= nxt;
  // level changes on entry to LEVEL_UP (wrapping increment) or LOSE (back to 0)
  always_ff @(posedge SC_LANECTRL_FSM_CLOCK_50 or negedge SC_LANECTRL_FSM_RESET_InLow)
    if (!SC_LANECTRL_FSM_RESET_InLow) level <= '0;
    else if (nxt == ST_LOSE) level <= '0;
    else if (nxt == ST_LEVEL_UP) level <= (level == LEVEL_W'(NUM_LEVELS-1)) ? '0 : level + LEVEL_W'(1);
  // next state: normal sequencing, then events override everywhere but RESET
  always_comb begin
    nxt = state;
    case (state)
      ST_RESET:          nxt = ST_START;
      ST_START:          nxt = ST_CHECK;
      ST_CHECK:          nxt = !start ? ST_INIT : |pend ? ST_SHIFT : ST_COUNT;
      ST_INIT, ST_NEST:  nxt = ST_WAIT_REL;
      ST_WAIT_REL:       nxt = start ? ST_CHECK : ST_WAIT_REL;
      ST_SHIFT:          nxt = ST_COUNT;
      ST_COUNT:          nxt = ST_CHECK;
      ST_LEVEL_UP:       nxt = ST_START;
`ifdef SC_LANECTRL_FSM_LOSE_HOLD_EN
      ST_LOSE:           nxt = start ? ST_LOSE : ST_INIT;
`else
      ST_LOSE:           nxt = ST_START;
`endif
      default:           nxt = ST_RESET;
    endcase
    if (state != ST_RESET)
      nxt = SC_LANECTRL_FSM_WINL ? ST_LEVEL_UP :
            SC_LANECTRL_FSM_WINF ? ST_NEST :
            SC_LANECTRL_FSM_Lose ? ST_LOSE :
            SC_LANECTRL_FSM_Change_BACKG ? ST_INIT : nxt;
  end
  // pending clears: everything on INIT/LEVEL_UP/LOSE, only the shifted lanes on SHIFT
  always_comb begin
    pclr = (state == ST_INIT || state == ST_LEVEL_UP || state == ST_LOSE) ? '1 :
           (state == ST_SHIFT) ? pend : '0;
  end
  // Moore control outputs
  always_comb begin
    SC_LANECTRL_FSM_clear_OutLow   = state != ST_INIT;
    SC_LANECTRL_FSM_load_OutLow    = !(state == ST_START || state == ST_INIT || state == ST_LEVEL_UP);
    SC_LANECTRL_FSM_upcount_OutLow = state != ST_COUNT;
    SC_LANECTRL_FSM_level_Out      = level;
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign SC_LANECTRL_FSM_shiftselection_Out[2*i +: 2] =
      (state == ST_SHIFT && pend[i]) ? sel_dir(DIR_MASK[i]) : SEL_HOLD;
  end
endmodule

// File: tb/tb_sc_lanectrl_fsm.sv
// tb_sc_lanectrl_fsm: table-driven directed check of the lane controller plus lose and reset sequences
module tb_sc_lanectrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n, start_n, winf, winl, lose, chg;
  logic [3:0] t0;
  logic       clear_n, load_n, up_n;
  logic [7:0] sel;
  logic [1:0] level;
  int         n_vec = 0;
  int         n_bad = 0;

  localparam logic [10:0] I  = {3'b111, 8'hFF};
  localparam logic [10:0] LD = {3'b101, 8'hFF};
  localparam logic [10:0] UP = {3'b110, 8'hFF};
  localparam logic [10:0] IN = {3'b001, 8'hFF};
  localparam logic [10:0] SH = {3'b111, 8'hF9};

  typedef struct {
    logic        st;
    logic [3:0]  t0;
    logic [3:0]  ev;
    logic [12:0] exp;
  } vec_t;
  vec_t vq[$];

  sc_lanectrl_fsm dut (
    .SC_LANECTRL_FSM_CLOCK_50           (clk),
    .SC_LANECTRL_FSM_RESET_InLow        (rst_n),
    .SC_LANECTRL_FSM_startButton_InLow  (start_n),
    .SC_LANECTRL_FSM_T0_InLow           (t0),
    .SC_LANECTRL_FSM_WINF               (winf),
    .SC_LANECTRL_FSM_WINL               (winl),
    .SC_LANECTRL_FSM_Lose               (lose),
    .SC_LANECTRL_FSM_Change_BACKG       (chg),
    .SC_LANECTRL_FSM_clear_OutLow       (clear_n),
    .SC_LANECTRL_FSM_load_OutLow        (load_n),
    .SC_LANECTRL_FSM_upcount_OutLow     (up_n),
    .SC_LANECTRL_FSM_shiftselection_Out (sel),
    .SC_LANECTRL_FSM_level_Out          (level)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, input logic [3:0] t, input logic [3:0] e, input logic [10:0] p, input logic [1:0] lv);
    vec_t v;
    v.st = s; v.t0 = t; v.ev = e; v.exp = {p, lv};
    vq.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [3:0] t, input logic [3:0] e);
    start_n = s; t0 = t;
    {winl, winf, lose, chg} = e;
  endtask

  task automatic check(input string name, input logic [10:0] p, input logic [1:0] lv);
    logic [12:0] act, exp;
    act = {clear_n, load_n, up_n, sel, level};
    exp = {p, lv};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got clr=%b ld=%b up=%b sel=%h lvl=%0d, want clr=%b ld=%b up=%b sel=%h lvl=%0d",
               name, act[12], act[11], act[10], act[9:2], act[1:0], exp[12], exp[11], exp[10], exp[9:2], exp[1:0]);
    end
  endtask

  task automatic step(input string name, input logic [10:0] p, input logic [1:0] lv);
    @(posedge clk);
    #1;
    check(name, p, lv);
  endtask

  initial begin
    add(1, 4'hF, 4'h0, LD, 0); add(1, 4'hF, 4'h0, I, 0);  add(1, 4'hF, 4'h0, UP, 0);
    add(1, 4'hF, 4'h0, I, 0);  add(1, 4'hF, 4'h0, UP, 0); add(1, 4'hC, 4'h0, I, 0);
    add(1, 4'hF, 4'h0, SH, 0); add(1, 4'hF, 4'h0, UP, 0); add(1, 4'hF, 4'h0, I, 0);
    add(1, 4'hF, 4'h0, UP, 0); add(1, 4'hF, 4'h8, LD, 1); add(1, 4'hF, 4'h0, LD, 1);
    add(1, 4'hF, 4'h8, LD, 2); add(1, 4'hF, 4'h0, LD, 2); add(1, 4'hF, 4'h8, LD, 3);
    add(1, 4'hF, 4'h0, LD, 3); add(1, 4'hF, 4'h8, LD, 0); add(1, 4'hF, 4'h0, LD, 0);
    add(1, 4'hF, 4'h0, I, 0);  add(1, 4'hF, 4'h0, UP, 0); add(1, 4'hF, 4'hC, LD, 1);
    add(1, 4'hF, 4'h0, LD, 1); add(1, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h4, I, 1);
    add(1, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h0, UP, 1);
    add(0, 4'hF, 4'h0, I, 1);  add(0, 4'hF, 4'h0, IN, 1); add(0, 4'hF, 4'h0, I, 1);
    add(0, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h0, UP, 1);
    add(1, 4'hF, 4'h1, IN, 1); add(1, 4'hF, 4'h0, I, 1);  add(1, 4'hF, 4'h0, I, 1);
    add(1, 4'hF, 4'h0, UP, 1);
    rst_n = 1'b0;
    drive(1, 4'hF, 4'h0);
    @(posedge clk);
    #1;
    check("reset", I, 0);
    rst_n = 1'b1;
    foreach (vq[k]) begin
      drive(vq[k].st, vq[k].t0, vq[k].ev);
      step($sformatf("vec%0d", k), vq[k].exp[12:2], vq[k].exp[1:0]);
    end
    drive(1, 4'hF, 4'h2);
    step("lose_enter", I, 0);
`ifdef SC_LANECTRL_FSM_LOSE_HOLD_EN
    for (int c = 0; c < 10; c++) begin
      drive(1, 4'h0, 4'h0);
      step($sformatf("lose_hold%0d", c), I, 0);
    end
    drive(0, 4'hF, 4'h0);
    step("lose_init", IN, 0);
    drive(1, 4'hF, 4'h0);
    step("lose_wait", I, 0);
`else
    drive(1, 4'hF, 4'h0);
    step("lose_start", LD, 0);
`endif
    step("lose_check", I, 0);
    step("lose_count", UP, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step("rs_start", LD, 0);
    drive(1, 4'hF, 4'h8);
    step("rs_lvlup", LD, 1);
    drive(1, 4'hF, 4'h0);
    step("rs_start2", LD, 1);
    drive(1, 4'h0, 4'h0);
    step("rs_check", I, 1);
    drive(1, 4'hF, 4'h0);
    step("rs_shift", {3'b111, 8'h99}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async", I, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rs_after_start", LD, 0);
    step("rs_after_check", I, 0);
    step("rs_after_count", UP, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sc_lanectrl_fsm.md
SC_LANECTRL_FSM -- requirements
Module: sc_lanectrl_fsm

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of independently shifted background lanes.
REQ-002 SHALL have parameter NUM_LEVELS, default 4: level count; LEVEL_W, default 2: level_Out width.
REQ-003 SHALL have parameter DIR_MASK, NUM_LANES bits, default 4'b0101: bit i=1 means lane i shifts right, 0 means left.
REQ-004 SC_LANECTRL_FSM_CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-005 SC_LANECTRL_FSM_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-006 SC_LANECTRL_FSM_startButton_InLow  in  1  start/restart button, active-low level.
REQ-007 SC_LANECTRL_FSM_T0_InLow  in  NUM_LANES  per-lane shift tick, active-low.
REQ-008 SC_LANECTRL_FSM_WINF / _WINL / _Lose / _Change_BACKG  in  1 each  nest reached / level won / frog lost / map refresh, active-high.
REQ-009 SC_LANECTRL_FSM_clear_OutLow, _load_OutLow, _upcount_OutLow  out  1 each  register clear, map load, timer count enables, active-low.
REQ-010 SC_LANECTRL_FSM_shiftselection_Out  out  2*NUM_LANES  per-lane code: 11 hold, 10 left, 01 right.
REQ-011 SC_LANECTRL_FSM_level_Out  out  LEVEL_W  current level index.

Function
REQ-012 States SHALL be RESET, START, CHECK, INIT, WAIT_REL, SHIFT, COUNT, NEST, LEVEL_UP, LOSE; outputs SHALL be Moore, decoded from the state register and the pending register.
REQ-013 Idle outputs SHALL be clear=1, load=1, upcount=1, all lanes 11; each state overrides only the outputs listed for it.
REQ-014 RESET->START unconditionally; START drives load=0 for one cycle, then moves to CHECK.
REQ-015 CHECK priority: start=0 -> INIT; else any pending -> SHIFT; else -> COUNT.
REQ-016 INIT drives clear=0 and load=0 for one cycle, clears all pending bits, then moves to WAIT_REL.
REQ-017 WAIT_REL SHALL hold until start=1, then move to CHECK.
REQ-018 A per-lane pending bit SHALL set on any cycle T0[i]=0; if set and clear coincide, set wins.
REQ-019 SHIFT drives code 10 or 01 (per DIR_MASK) for every pending lane and 11 for the others, lasts one cycle, clears the shifted lanes' pending bits, then moves to COUNT.
REQ-020 COUNT drives upcount=0 for one cycle, then moves to CHECK.
REQ-021 Events SHALL override next-state in every state except RESET, with priority WINL > WINF > Lose > Change_BACKG.
REQ-022 WINF -> NEST: one idle cycle, then WAIT_REL.
REQ-023 WINL -> LEVEL_UP: level increments, wrapping from NUM_LEVELS-1 to 0; load=0 for one cycle; pending cleared; then START.
REQ-024 Change_BACKG SHALL force INIT.
REQ-025 Lose -> LOSE: level set to 0, pending cleared, all outputs idle; behaviour follows REQ-029/030.

Reset
REQ-026 On RESET_InLow=0, the state SHALL become RESET, pending 0 and level 0 immediately, without waiting for a clock edge.
REQ-027 Output values in reset SHALL be clear=1, load=1, upcount=1, all lanes 11, level_Out=0.
REQ-028 A reset during SHIFT or LEVEL_UP SHALL abort the operation; no partial level increment is retained.

Configuration
REQ-029 With SC_LANECTRL_FSM_LOSE_HOLD_EN defined, LOSE SHALL persist and ignore ticks until start=0, then go to INIT.
REQ-030 Without SC_LANECTRL_FSM_LOSE_HOLD_EN, LOSE SHALL last one cycle, then go to START.

Structure
REQ-031 The shared package sc_lanectrl_pkg SHALL hold the state encodings (4-bit) and the shift codes SEL_HOLD, SEL_LEFT and SEL_RIGHT.
REQ-032 The per-lane pending set/clear logic SHALL be the sub-module sc_lanectrl_pending, instantiated once with width NUM_LANES.

Verification
REQ-033 Reset release, then hold start=1 with no ticks -> load=0 exactly one cycle after START, then CHECK/COUNT alternating with upcount=0 every second cycle.
REQ-034 T0=4'b1100 for one cycle, DIR_MASK=0101 -> a single SHIFT cycle with shiftselection=11_11_10_01, then a COUNT cycle.
REQ-035 With level=3 and NUM_LEVELS=4, pulse WINL -> level_Out=0 and load=0 for one cycle, then START.
REQ-036 WINF and WINL asserted in the same cycle -> LEVEL_UP is taken and NEST is not.
REQ-037 Pulse Lose, then hold start=0 after 10 cycles -> with the macro defined, no shift until start, then INIT with clear=0; without the macro, START on the next cycle.
REQ-038 Assert reset mid-SHIFT -> outputs return to their idle values immediately, with pending=0 and level=0.
